// File: rtl/run_detect_ctrl_if.sv
// Host/line bundle for run_detect_ctrl: master = host + serial line driver, slave = controller.
// Handshake: start is taken only while the controller sits idle (busy=0, not in its done cycle);
// otherwise it is dropped, never queued. done is a one-cycle pulse and hit is valid from done until the next accepted start.
interface run_detect_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int WIN_W = 8,
  parameter int HIT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] thresh;
  logic [WIN_W-1:0] window;
  logic             in;
  logic             abort;
  logic             busy;
  logic             done;
  logic             hit;
  logic [CNT_W-1:0] max_run;
  logic [HIT_W-1:0] hit_count;

  modport master (
    output start, thresh, window, in, abort,
    input  busy, done, hit, max_run, hit_count
  );

  modport slave (
    input  start, thresh, window, in, abort,
    output busy, done, hit, max_run, hit_count
  );
endinterface

// File: rtl/run_detect_ctrl.sv
// Run-of-ones detection sequencer: qualify idle-low, count consecutive ones, report hit or window timeout.
// Define RUN_DETECT_RETRIGGER_EN for continuous mode (hits re-arm until the window expires).
module run_detect_ctrl #(
  parameter int CNT_W = 4,
  parameter int WIN_W = 8,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  run_detect_ctrl_if.slave bus,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [HIT_W-1:0] HIT_ONE = HIT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_thr, w_thr_nxt;
  logic [WIN_W-1:0] r_win, w_win_nxt;
  logic [WIN_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0] r_run, w_run_nxt;
  logic [CNT_W-1:0] r_max_run, w_max_nxt;
  logic [HIT_W-1:0] r_hit_count, w_hcnt_nxt;
  logic             r_hit, w_hit_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
`ifdef RUN_DETECT_RETRIGGER_EN
  logic             r_any_hit, w_any_nxt;
`endif

  logic             w_active;
  logic             w_expire;
  logic             w_hit;
  logic [CNT_W-1:0] w_run_inc;

  // abort is folded into w_hit so a coinciding hit never counts
  assign w_active  = (r_state == S_ARM) || (r_state == S_RUN);
  assign w_expire  = w_active && (r_win != '0) && (r_wcnt == (r_win - WIN_ONE));
  assign w_hit     = (r_state == S_RUN) && bus.in && !bus.abort && (r_run == (r_thr - CNT_ONE));
  assign w_run_inc = (r_run == '1) ? r_run : (r_run + CNT_ONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_thr       <= '0;
      r_win       <= '0;
      r_wcnt      <= '0;
      r_run       <= '0;
      r_max_run   <= '0;
      r_hit_count <= '0;
      r_hit       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef RUN_DETECT_RETRIGGER_EN
      r_any_hit   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_thr       <= w_thr_nxt;
      r_win       <= w_win_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_run       <= w_run_nxt;
      r_max_run   <= w_max_nxt;
      r_hit_count <= w_hcnt_nxt;
      r_hit       <= w_hit_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
`ifdef RUN_DETECT_RETRIGGER_EN
      r_any_hit   <= w_any_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_ARM;
      // a line already high at start must fall before ones count
      S_ARM: begin
        if (bus.abort)       w_state_nxt = S_IDLE;
        else if (w_expire)   w_state_nxt = S_DONE;
        else if (!bus.in)    w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.abort)       w_state_nxt = S_IDLE;
`ifdef RUN_DETECT_RETRIGGER_EN
        else if (w_hit)      w_state_nxt = w_expire ? S_DONE : S_ARM;
`else
        else if (w_hit)      w_state_nxt = S_DONE;
`endif
        else if (w_expire)   w_state_nxt = S_DONE;
      end
      S_DONE:                w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_thr_nxt  = r_thr;
    w_win_nxt  = r_win;
    w_wcnt_nxt = r_wcnt;
    w_run_nxt  = r_run;
    w_max_nxt  = r_max_run;
    w_hcnt_nxt = r_hit_count;
    w_hit_nxt  = r_hit;
`ifdef RUN_DETECT_RETRIGGER_EN
    w_any_nxt  = r_any_hit;
`endif
    w_busy_nxt = (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);

    if ((r_state == S_IDLE) && bus.start) begin
      w_thr_nxt  = (bus.thresh == '0) ? CNT_ONE : bus.thresh;
      w_win_nxt  = bus.window;
      w_wcnt_nxt = '0;
      w_run_nxt  = '0;
      w_max_nxt  = '0;
      w_hit_nxt  = 1'b0;
`ifdef RUN_DETECT_RETRIGGER_EN
      w_any_nxt  = 1'b0;
`endif
    end

    if (w_active) w_wcnt_nxt = r_wcnt + WIN_ONE;

    // the sample taken alongside an abort still feeds max_run
    if (r_state == S_RUN) begin
      if (bus.in) begin
        w_run_nxt = w_run_inc;
        if (w_run_inc > r_max_run) w_max_nxt = w_run_inc;
      end else begin
        w_run_nxt = '0;
      end
    end

    if (w_hit && (r_hit_count != '1)) w_hcnt_nxt = r_hit_count + HIT_ONE;

`ifdef RUN_DETECT_RETRIGGER_EN
    if (w_active) w_hit_nxt = 1'b0;
    if (w_hit) begin
      w_any_nxt = 1'b1;
      w_run_nxt = '0;
      w_hit_nxt = 1'b1;
    end
    if (w_state_nxt == S_DONE) w_hit_nxt = r_any_hit | w_hit;
`else
    if (w_hit) w_hit_nxt = 1'b1;
`endif
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.hit       = r_hit;
  assign bus.max_run   = r_max_run;
  assign bus.hit_count = r_hit_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Bench for run_detect_ctrl: directed scenarios plus randomized runs scored against a run-level model.
// A second instance with a 2-bit hit counter sees identical stimulus to exercise saturation.
module tb_run_detect_ctrl;
  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int HIT_W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_sat;

  int n_total;
  int n_pass;
  int n_fail;
  int total_hits;
  bit exp_hit;
  int exp_max;

  run_detect_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W), .HIT_W(HIT_W)) bif ();
  run_detect_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W), .HIT_W(2))     sif ();

  assign sif.start  = bif.start;
  assign sif.thresh = bif.thresh;
  assign sif.window = bif.window;
  assign sif.in     = bif.in;
  assign sif.abort  = bif.abort;

  run_detect_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .HIT_W(HIT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif.slave),
    .o_dbg_state (dbg_state)
  );

  run_detect_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .HIT_W(2)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .bus         (sif.slave),
    .o_dbg_state (dbg_state_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input bit e_busy, input bit e_done,
                           input bit e_hit, input int e_max);
    int e_cnt;
    int e_sat;
    e_cnt = (total_hits > 255) ? 255 : total_hits;
    e_sat = (total_hits > 3) ? 3 : total_hits;
    chk({tag, "_busy"},    32'(bif.busy),      32'(e_busy));
    chk({tag, "_done"},    32'(bif.done),      32'(e_done));
    chk({tag, "_hit"},     32'(bif.hit),       32'(e_hit));
    chk({tag, "_max_run"}, 32'(bif.max_run),   e_max);
    chk({tag, "_hit_cnt"}, 32'(bif.hit_count), e_cnt);
    chk({tag, "_sat_cnt"}, 32'(sif.hit_count), e_sat);
  endtask

  task automatic start_run(input int t_in, input int w_in);
    bif.start  = 1'b1;
    bif.thresh = CNT_W'(t_in);
    bif.window = WIN_W'(w_in);
    bif.abort  = 1'b0;
    bif.in     = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    bif.start = 1'b0;
    check_out("start", 1'b1, 1'b0, 1'b0, 0);
  endtask

  // Model: ones only count once the line has been seen low; a hit is the
  // thr-th consecutive one; the window allows exactly win samples.
  task automatic do_run(input int t_in, input int w_in, input logic s_q[$],
                        input int ab_k, output int end_cyc);
    int t, k, run_len, mx;
    bit qual, ended, hit_now, expire, ab, was_done;
    logic s;
    t = (t_in == 0) ? 1 : t_in;
    start_run(t_in, w_in);
    qual = 0; run_len = 0; mx = 0; k = 0; ended = 0; end_cyc = -1; was_done = 0;
    while (!ended) begin
      s  = (k < s_q.size()) ? s_q[k] : 1'b0;
      ab = (k == ab_k) || (k >= s_q.size());
      hit_now = 0;
      if (qual) begin
        if (s) begin
          if (run_len < 15) run_len++;
          if (run_len > mx) mx = run_len;
          hit_now = (run_len == t) && !ab;
        end else begin
          run_len = 0;
        end
      end else if (!s) begin
        qual = 1;
      end
      expire = (w_in != 0) && (k == w_in - 1);
      bif.in     = s;
      bif.abort  = ab;
      bif.start  = ($urandom_range(0, 2) == 0);
      bif.thresh = CNT_W'($urandom_range(0, 15));
      bif.window = WIN_W'($urandom_range(0, 255));
      @(posedge clk); #1;
      if (ab) begin
        exp_hit = 0; exp_max = mx; ended = 1;
        check_out("abort", 1'b0, 1'b0, 1'b0, mx);
      end else if (hit_now) begin
        total_hits++;
        exp_hit = 1; exp_max = mx; ended = 1; was_done = 1; end_cyc = k + 2;
        check_out("hit", 1'b0, 1'b1, 1'b1, mx);
      end else if (expire) begin
        exp_hit = 0; exp_max = mx; ended = 1; was_done = 1; end_cyc = k + 2;
        check_out("expire", 1'b0, 1'b1, 1'b0, mx);
      end else begin
        check_out("running", 1'b1, 1'b0, 1'b0, mx);
      end
      k++;
    end
    bif.abort  = 1'b0;
    bif.in     = 1'b0;
    bif.start  = was_done;
    bif.thresh = CNT_W'(1);
    bif.window = '0;
    @(posedge clk); #1;
    bif.start = 1'b0;
    check_out("after_end", 1'b0, 1'b0, exp_hit, exp_max);
    @(posedge clk); #1;
    check_out("idle_hold", 1'b0, 1'b0, exp_hit, exp_max);
  endtask

  initial begin
    logic sq[$];
    int   ec;
    n_total = 0; n_pass = 0; n_fail = 0; total_hits = 0;
    rst = 1'b0;
    bif.start = 1'b0; bif.thresh = '0; bif.window = '0; bif.in = 1'b0; bif.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef RUN_DETECT_RETRIGGER_EN
    sq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    start_run(2, 12);
    for (int k = 0; k < 12; k++) begin
      bif.in = sq[k];
      @(posedge clk); #1;
      if (k == 2 || k == 5 || k == 8) total_hits++;
      if (k < 11)
        check_out("retrig_run", 1'b1, 1'b0, (k == 2 || k == 5 || k == 8),
                  (k == 0) ? 0 : ((k == 1) ? 1 : 2));
      else
        check_out("retrig_done", 1'b0, 1'b1, 1'b1, 2);
    end
    bif.in = 1'b0;
    @(posedge clk); #1;
    check_out("retrig_idle", 1'b0, 1'b0, 1'b1, 2);
`else
    sq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_run(4, 0, sq, -1, ec);
    chk("lat_hit", ec, 6);
    chk("max_hit", 32'(bif.max_run), 4);

    sq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_run(4, 6, sq, -1, ec);
    chk("lat_window", ec, 7);
    chk("hit_window", 32'(bif.hit), 0);

    sq = '{};
    for (int i = 0; i < 10; i++) sq.push_back(1'b1);
    sq.push_back(1'b0); sq.push_back(1'b1); sq.push_back(1'b1);
    do_run(2, 0, sq, -1, ec);
    chk("lat_qualify", ec, 14);

    sq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_run(5, 0, sq, 3, ec);
    chk("max_abort", 32'(bif.max_run), 3);

    sq = '{1'b0, 1'b1, 1'b1};
    do_run(2, 0, sq, 2, ec);
    chk("abort_hit", 32'(bif.hit), 0);

    // synchronous reset during RUN after two hits
    start_run(5, 0);
    bif.in = 1'b0;
    @(posedge clk); #1;
    check_out("pre_rst0", 1'b1, 1'b0, 1'b0, 0);
    bif.in = 1'b1;
    @(posedge clk); #1;
    check_out("pre_rst1", 1'b1, 1'b0, 1'b0, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bif.in = 1'b0;
    total_hits = 0;
    check_out("mid_reset", 1'b0, 1'b0, 1'b0, 0);

    sq = '{1'b0, 1'b1};
    do_run(0, 0, sq, -1, ec);
    chk("lat_thr0", ec, 3);
    for (int i = 0; i < 3; i++) do_run(1, 0, sq, -1, ec);
    chk("sat_cnt", 32'(sif.hit_count), 3);
    chk("main_cnt", 32'(bif.hit_count), 4);

    for (int r = 0; r < 40; r++) begin
      int len, t_r, w_r, ab_r;
      len = $urandom_range(4, 20);
      sq = '{};
      for (int i = 0; i < len; i++) sq.push_back(1'($urandom_range(0, 3) != 0));
      t_r  = $urandom_range(0, 6);
      w_r  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 16);
      ab_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      do_run(t_r, w_r, sq, ab_r, ec);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
